// File: rtl/inst_fetch_ctrl.sv
// Purpose : instruction-fetch controller, one SRAM-like word read per PC, result held for decode.
// Latency : 4 cycles per aligned fetch on a zero-wait bus (IDLE, REQ, WAIT, DELIVER); 2 for a misaligned PC.
// Backpr. : stall_d holds the delivered slot; fetch_busy holds the PC stage until the slot is consumed.
//
// Ports:
//   clk, rst              clock, async active-low reset
//   pc, flush, stall_d    PC stage input, redirect/kill, decode back-pressure
//   fetch_busy            1 = PC stage must hold its PC
//   inst_req/wr/size/addr, inst_addr_ok/data_ok/rdata   instruction bus
//   instr, instr_pc, instr_valid, adel                  delivered slot to decode
module inst_fetch_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic             flush,
  input  logic             stall_d,
  output logic             fetch_busy,
  output logic             inst_req,
  output logic             inst_wr,
  output logic [1:0]       inst_size,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  output logic             adel
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DISCARD = 3'd3,
    DELIVER = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] buf_instr;
  logic [WIDTH-1:0] buf_pc;
  logic             buf_adel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      buf_instr <= '0;
      buf_pc    <= '0;
      buf_adel  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush) begin
            buf_pc <= pc;
            if (pc[1:0] != 2'b00) begin
              // Misaligned: skip the bus entirely and hand decode an error slot.
              buf_instr <= '0;
              buf_adel  <= 1'b1;
              state     <= DELIVER;
            end else begin
              req_addr <= pc;
              buf_adel <= 1'b0;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          // An accepted request must still be drained even if flushed, so the
          // bus never sees two outstanding reads.
          if (inst_addr_ok) begin
            state <= flush ? DISCARD : WAIT;
          end else if (flush) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (inst_data_ok) begin
            if (flush) begin
              state <= IDLE;
            end else begin
              buf_instr <= inst_rdata;
              state     <= DELIVER;
            end
          end else if (flush) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (inst_data_ok) begin
            state <= IDLE;
          end
        end
        DELIVER: begin
          // Buffers stay untouched while decode stalls.
          if (flush || !stall_d) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign inst_req    = (state == REQ);
  assign inst_wr     = 1'b0;
  assign inst_size   = 2'b10;
  assign inst_addr   = req_addr;
  assign instr       = buf_instr;
  assign instr_pc    = buf_pc;
  assign adel        = buf_adel;
  // A flush in DELIVER kills the slot in the same cycle.
  assign instr_valid = (state == DELIVER) && !flush;
  // The PC stage may advance only on the edge where decode takes the slot.
  assign fetch_busy  = (state == DELIVER) ? (stall_d | flush) : 1'b1;

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch controller sitting directly downstream of the PC-generation stage and upstream of the IF/ID pipeline register. It takes the current PC and issues one SRAM-like read per instruction on the instruction bus. It holds the PC stage through the fetch busy output, and delivers the fetched instruction with its PC to decode. A flush kills any in-flight fetch; misaligned PCs raise an address-error flag instead of a bus request.

## Interface
- WIDTH, 32, address/data width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pc  in  WIDTH  current PC from the PC stage
- flush  in  1  redirect/exception; kills in-flight fetch and pending delivery
- stall_d  in  1  decode cannot accept an instruction this cycle
- fetch_busy  out  1  to PC stage stall input; 1 = hold PC
- inst_req  out  1  bus request
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10 (word)
- inst_addr  out  WIDTH  request address
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  WIDTH  read data
- instr  out  WIDTH  delivered instruction
- instr_pc  out  WIDTH  PC of delivered instruction
- instr_valid  out  1  instr/instr_pc/adel valid this cycle
- adel  out  1  delivered slot is an instruction-fetch address error

## Operation
- States: IDLE, REQ, WAIT, DISCARD, DELIVER. Registers: state, req_addr, buf_instr, buf_pc, buf_adel.
- IDLE: inst_req=0, fetch_busy=1.
  - flush -> IDLE.
  - pc[1:0]!=0 -> buf_instr=0, buf_pc=pc, buf_adel=1 -> DELIVER.
  - otherwise -> req_addr=pc, buf_pc=pc, buf_adel=0 -> REQ.
- REQ: inst_req=1, inst_addr=req_addr, fetch_busy=1.
  - addr_ok & flush -> DISCARD.
  - addr_ok -> WAIT.
  - flush without addr_ok -> IDLE; the request is withdrawn.
- WAIT: inst_req=0, fetch_busy=1.
  - data_ok & flush -> IDLE; data dropped.
  - data_ok -> buf_instr=inst_rdata -> DELIVER.
  - flush without data_ok -> DISCARD.
- DISCARD: inst_req=0, fetch_busy=1, instr_valid=0.
  - data_ok -> IDLE.
  - Flushes in this state are absorbed.
- DELIVER: instr_valid = !flush; instr/instr_pc/adel are driven from the buffers; fetch_busy = stall_d | flush.
  - flush -> IDLE; nothing delivered.
  - !stall_d -> IDLE; the instruction is consumed on this edge and the PC stage advances on the same edge.
  - stall_d -> stay in DELIVER, with the buffers held stable.
- At most one bus transaction is outstanding. No new request is issued until the outstanding data_ok arrives, including in DISCARD.
- inst_addr equals req_addr in all states.
- Outside DELIVER, instr/instr_pc/adel show the buffer contents, but instr_valid=0.

## Timing
- Reset (rst=0, async): state=IDLE, req_addr=0, buffers=0. Outputs: inst_req=0, instr_valid=0, adel=0, instr=0, instr_pc=0, fetch_busy=1.
- Minimum cycles per instruction is 4 (IDLE, REQ, WAIT, DELIVER), when addr_ok arrives in the first REQ cycle and data_ok in the first WAIT cycle.
- A misaligned PC takes 2 cycles (IDLE, DELIVER) with no bus activity.
- Each cycle of addr_ok or data_ok delay adds one cycle. Each stall_d cycle in DELIVER adds one cycle.
- inst_req, once asserted, stays high until addr_ok or flush.
- data_ok in REQ or IDLE is illegal from the bus; the block ignores it.
- Simultaneous flush and handshake resolve per the state rules above; flush always wins over delivery.

## Test plan
- Aligned fetch, zero-wait bus: pc=0xbfc00000, addr_ok asserted in the first REQ cycle, data_ok in the following cycle with rdata=0x24080001. Expect instr_valid=1 on cycle 3 after reset release with instr=0x24080001 and instr_pc=0xbfc00000, fetch_busy=0 that cycle, and inst_req high for exactly one cycle.
- Back-pressure: same fetch with stall_d=1 for 3 cycles in DELIVER. Expect instr_valid held for 4 cycles, fetch_busy=1 for the first 3, and instr stable throughout.
- Flush while waiting: flush pulse in the WAIT cycle, data_ok 2 cycles later with 0xdeadbeef. Expect no instr_valid for 0xdeadbeef, no new inst_req until after that data_ok, and the next fetch to use the redirected pc.
- Misaligned PC: pc=0xbfc00002. Expect inst_req never asserted, and instr_valid=1 with adel=1, instr=0, instr_pc=0xbfc00002 one cycle after IDLE.
- Slow bus: addr_ok delayed 3 cycles, data_ok delayed 2 more. Expect inst_req high for 4 cycles with inst_addr constant, and fetch_busy=1 until DELIVER.
- Reset mid-fetch: rst low during WAIT. Expect immediate async return to IDLE with all outputs at their reset values, and a clean fetch of the new pc after release.
